// File: rtl/img_proc_pkg.sv
// Shared types and default widths for the multi-lane pixel processing engine.
//   proc_mode_e  : per-frame point operation selected by slv_mode (6/7 behave as pass)
//   proc_state_e : frame sequencing states of image_proc_lanes
package img_proc_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned DEF_PIX_WIDTH  = 8;
    localparam int unsigned DEF_CNT_WIDTH  = 16;

    typedef enum logic [2:0] {
        MODE_PASS  = 3'd0,
        MODE_ADD   = 3'd1,
        MODE_SUB   = 3'd2,
        MODE_INV   = 3'd3,
        MODE_THR   = 3'd4,
        MODE_CLAMP = 3'd5
    } proc_mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } proc_state_e;

endpackage

// File: rtl/pix_lane_op.sv
// Combinational point operation on a single unsigned pixel lane.
// Ports:
//   mode    : operation select (proc_mode_e encoding; unused codes pass through)
//   pix     : input pixel
//   operand : per-frame operand v
//   result  : processed pixel, saturated to [0, 2^PIX_WIDTH-1]
module pix_lane_op
    import img_proc_pkg::*;
#(
    parameter int unsigned PIX_WIDTH = DEF_PIX_WIDTH
) (
    input  logic [2:0]           mode,
    input  logic [PIX_WIDTH-1:0] pix,
    input  logic [PIX_WIDTH-1:0] operand,
    output logic [PIX_WIDTH-1:0] result
);

    // One extra bit captures the carry used for add saturation.
    logic [PIX_WIDTH:0] sum;

    always_comb begin
        sum    = {1'b0, pix} + {1'b0, operand};
        result = pix;
        case (mode)
            MODE_PASS:  result = pix;
            MODE_ADD:   result = sum[PIX_WIDTH] ? '1 : sum[PIX_WIDTH-1:0];
            MODE_SUB:   result = (pix >= operand) ? (pix - operand) : '0;
            MODE_INV:   result = ~pix;
            MODE_THR:   result = (pix >= operand) ? '1 : '0;
            MODE_CLAMP: result = (pix < operand) ? pix : operand;
            default:    result = pix;
        endcase
    end

endmodule

// File: rtl/image_proc_lanes.sv
// Multi-lane pixel processing engine. Each slave word is split into
// NUM_PIX = DATA_WIDTH/PIX_WIDTH lanes, processed by a per-frame point
// operation and written to the output FIFO through a 2-stage stall-able
// pipeline. A frame of frame_words words ends with a one-cycle
// mstr_data_cmplt pulse.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   start             : latches slv_mode/slv_proc_val/frame_words when idle
//   slv_mode          : operation select
//   slv_proc_val      : operand applied to every lane
//   frame_words       : number of words in the frame (0 = empty frame)
//   slv_data_valid    : slave word valid
//   slv_data          : slave word, lane i = bits [i*PIX_WIDTH +: PIX_WIDTH]
//   slv_data_ready    : slave word accepted when valid && ready
//   fifo_full         : output FIFO full
//   wr                : output FIFO write strobe
//   data_out          : processed word
//   mstr_data_cmplt   : frame-complete pulse
//   busy              : high whenever not idle
module image_proc_lanes
    import img_proc_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned PIX_WIDTH  = DEF_PIX_WIDTH,
    parameter int unsigned CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [2:0]            slv_mode,
    input  logic [PIX_WIDTH-1:0]  slv_proc_val,
    input  logic [CNT_WIDTH-1:0]  frame_words,
    input  logic                  slv_data_valid,
    input  logic [DATA_WIDTH-1:0] slv_data,
    output logic                  slv_data_ready,
    input  logic                  fifo_full,
    output logic                  wr,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  mstr_data_cmplt,
    output logic                  busy
);

    localparam int unsigned NUM_PIX = DATA_WIDTH / PIX_WIDTH;

    proc_state_e           state;
    logic [2:0]            mode_q;
    logic [PIX_WIDTH-1:0]  val_q;
    logic [CNT_WIDTH-1:0]  words_q;
    logic [CNT_WIDTH-1:0]  acc_cnt;
    logic [CNT_WIDTH-1:0]  wr_cnt;

    logic                  v1;
    logic                  v2;
    logic [DATA_WIDTH-1:0] d1;
    logic [DATA_WIDTH-1:0] result;
    logic                  adv1;
    logic                  adv2;
    logic                  accept;

    // Stage 2 drains whenever the FIFO has room; stage 1 moves when stage 2
    // is empty or draining in the same cycle, so a stall release writes and
    // shifts at once.
    always_comb begin
        adv2           = !v2 || !fifo_full;
        adv1           = !v1 || adv2;
        wr             = v2 && !fifo_full;
        slv_data_ready = (state == RUN) && (acc_cnt < words_q) && adv1;
        accept         = slv_data_valid && slv_data_ready;
    end

    for (genvar i = 0; i < NUM_PIX; i++) begin : g_lane
        pix_lane_op #(
            .PIX_WIDTH (PIX_WIDTH)
        ) u_op (
            .mode    (mode_q),
            .pix     (d1[i*PIX_WIDTH +: PIX_WIDTH]),
            .operand (val_q),
            .result  (result[i*PIX_WIDTH +: PIX_WIDTH])
        );
    end

    // Frame sequencing, counters and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            mode_q          <= '0;
            val_q           <= '0;
            words_q         <= '0;
            acc_cnt         <= '0;
            wr_cnt          <= '0;
            busy            <= 1'b0;
            mstr_data_cmplt <= 1'b0;
        end else begin
            mstr_data_cmplt <= 1'b0;
            if (accept) acc_cnt <= acc_cnt + 1'b1;
            if (wr)     wr_cnt  <= wr_cnt + 1'b1;
            case (state)
                IDLE: begin
                    if (start) begin
                        mode_q  <= slv_mode;
                        val_q   <= slv_proc_val;
                        words_q <= frame_words;
                        busy    <= 1'b1;
                        if (frame_words != '0) begin
                            state   <= RUN;
                            acc_cnt <= '0;
                            wr_cnt  <= '0;
                        end else begin
                            state           <= DONE;
                            mstr_data_cmplt <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (acc_cnt == words_q) state <= DRAIN;
                end
                DRAIN: begin
                    if (wr_cnt == words_q) begin
                        state           <= DONE;
                        mstr_data_cmplt <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Two-stage datapath; data_out is the stage-2 register and holds while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1       <= 1'b0;
            v2       <= 1'b0;
            d1       <= '0;
            data_out <= '0;
        end else begin
            if (adv1) begin
                v1 <= accept;
                if (accept) d1 <= slv_data;
            end
            if (adv2) begin
                v2 <= v1;
                if (v1) data_out <= result;
            end
        end
    end

endmodule
